// File: rtl/fifo_lvl_pkg.sv
// Shared constants and types for the level-tracking FIFO.
//   FIFO_B_DEFAULT / FIFO_W_DEFAULT : default word width and address width
//   fifo_depth(w)                   : number of words for a given address width (2**w)
//   fifo_flags_t                    : registered occupancy status flags
package fifo_lvl_pkg;

    localparam int unsigned FIFO_B_DEFAULT = 8;
    localparam int unsigned FIFO_W_DEFAULT = 4;

    function automatic int unsigned fifo_depth(input int unsigned w);
        return 32'd1 << w;
    endfunction

    typedef struct packed {
        logic empty;
        logic full;
        logic almost_empty;
        logic almost_full;
    } fifo_flags_t;

    localparam fifo_flags_t FIFO_FLAGS_RESET = '{
        empty:        1'b1,
        full:         1'b0,
        almost_empty: 1'b1,
        almost_full:  1'b0
    };

endpackage

// File: rtl/fifo_lvl_if.sv
// Producer/consumer bus of the level-tracking FIFO.
//   master : drives clr, wr, w_data, rd; observes data and status
//   slave  : the FIFO itself
//   clr          synchronous flush
//   wr, w_data   write request and data
//   rd, r_data   read request and show-ahead head word
//   empty, full, almost_empty, almost_full, level   occupancy status (registered)
//   overflow, underflow                             sticky error flags
interface fifo_lvl_if
    import fifo_lvl_pkg::*;
#(
    parameter int unsigned B = FIFO_B_DEFAULT,
    parameter int unsigned W = FIFO_W_DEFAULT
) ();

    logic         clr;
    logic         wr;
    logic [B-1:0] w_data;
    logic         rd;
    logic [B-1:0] r_data;
    logic         empty;
    logic         full;
    logic         almost_empty;
    logic         almost_full;
    logic [W:0]   level;
    logic         overflow;
    logic         underflow;

    modport master (
        output clr, wr, w_data, rd,
        input  r_data, empty, full, almost_empty, almost_full, level, overflow, underflow
    );

    modport slave (
        input  clr, wr, w_data, rd,
        output r_data, empty, full, almost_empty, almost_full, level, overflow, underflow
    );

endinterface

// File: rtl/fifo_regfile.sv
// 2**W x B storage array for the FIFO.
//   clk    : write clock
//   we     : write enable, waddr/wdata captured on rising edge
//   raddr  : asynchronous read address, rdata follows it combinationally
// Contents are deliberately not reset.
module fifo_regfile
    import fifo_lvl_pkg::*;
#(
    parameter int unsigned B = FIFO_B_DEFAULT,
    parameter int unsigned W = FIFO_W_DEFAULT
) (
    input  logic         clk,
    input  logic         we,
    input  logic [W-1:0] waddr,
    input  logic [B-1:0] wdata,
    input  logic [W-1:0] raddr,
    output logic [B-1:0] rdata
);

    localparam int unsigned Depth = fifo_depth(W);

    logic [B-1:0] mem [Depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_lvl.sv
// Synchronous FIFO with occupancy level, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and synchronous flush.
//   clk   : clock, all state changes on rising edge
//   reset : asynchronous, active-high
//   bus   : fifo_lvl_if slave (clr, wr/w_data, rd/r_data, status and error flags)
// All status outputs are registered from the next-state level, so there is no
// combinational path from rd/wr to any flag.
module fifo_lvl
    import fifo_lvl_pkg::*;
#(
    parameter int unsigned B      = FIFO_B_DEFAULT,
    parameter int unsigned W      = FIFO_W_DEFAULT,
    parameter int unsigned AF_LVL = fifo_depth(W) - 2,
    parameter int unsigned AE_LVL = 1
) (
    input logic       clk,
    input logic       reset,
    fifo_lvl_if.slave bus
);

    localparam int unsigned Depth = fifo_depth(W);
    localparam int unsigned LvlW  = W + 1;
    localparam logic [W:0]  DepthLvl = LvlW'(Depth);
    localparam logic [W:0]  AfLvl    = LvlW'(AF_LVL);
    localparam logic [W:0]  AeLvl    = LvlW'(AE_LVL);

    logic [W-1:0] w_ptr_q, w_ptr_d;
    logic [W-1:0] r_ptr_q, r_ptr_d;
    logic [W:0]   level_q, level_d;
    fifo_flags_t  flags_q, flags_d;
    logic         overflow_q, overflow_d;
    logic         underflow_q, underflow_d;
    logic         wr_acc, rd_acc;
    logic         mem_we;

    // A write into a full FIFO is legal when a pop frees the head slot on the same edge.
    assign wr_acc = bus.wr & (~flags_q.full | bus.rd);
    assign rd_acc = bus.rd & ~flags_q.empty;
    assign mem_we = wr_acc & ~bus.clr;

    always_comb begin
        w_ptr_d     = w_ptr_q;
        r_ptr_d     = r_ptr_q;
        level_d     = level_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (bus.clr) begin
            w_ptr_d     = '0;
            r_ptr_d     = '0;
            level_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            w_ptr_d     = w_ptr_q + {{(W-1){1'b0}}, wr_acc};
            r_ptr_d     = r_ptr_q + {{(W-1){1'b0}}, rd_acc};
            level_d     = level_q + {{W{1'b0}}, wr_acc} - {{W{1'b0}}, rd_acc};
            overflow_d  = overflow_q | (bus.wr & ~wr_acc);
            underflow_d = underflow_q | (bus.rd & ~rd_acc);
        end
        flags_d.empty        = (level_d == '0);
        flags_d.full         = (level_d == DepthLvl);
        flags_d.almost_empty = (level_d <= AeLvl);
        flags_d.almost_full  = (level_d >= AfLvl);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_ptr_q     <= '0;
            r_ptr_q     <= '0;
            level_q     <= '0;
            flags_q     <= FIFO_FLAGS_RESET;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            w_ptr_q     <= w_ptr_d;
            r_ptr_q     <= r_ptr_d;
            level_q     <= level_d;
            flags_q     <= flags_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_regfile #(
        .B (B),
        .W (W)
    ) u_regfile (
        .clk   (clk),
        .we    (mem_we),
        .waddr (w_ptr_q),
        .wdata (bus.w_data),
        .raddr (r_ptr_q),
        .rdata (bus.r_data)
    );

    assign bus.empty        = flags_q.empty;
    assign bus.full         = flags_q.full;
    assign bus.almost_empty = flags_q.almost_empty;
    assign bus.almost_full  = flags_q.almost_full;
    assign bus.level        = level_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_lvl.sv
// Scoreboard bench for fifo_lvl at B=8, W=2 (depth 4), AF_LVL=3, AE_LVL=1.
module tb_fifo_lvl;

    logic clk = 1'b0;
    logic reset;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    fifo_lvl_if #(.B(8), .W(2)) bus ();

    fifo_lvl #(
        .B      (8),
        .W      (2),
        .AF_LVL (3),
        .AE_LVL (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Status snapshot: level, empty, full, almost_empty, almost_full, overflow, underflow.
    task automatic check_status(input string tag, input int lvl, input logic e, input logic f,
                                input logic ae, input logic af, input logic ov, input logic un);
        check({tag, ".level"}, 32'(bus.level), 32'(lvl));
        check({tag, ".empty"}, 32'(bus.empty), 32'(e));
        check({tag, ".full"}, 32'(bus.full), 32'(f));
        check({tag, ".almost_empty"}, 32'(bus.almost_empty), 32'(ae));
        check({tag, ".almost_full"}, 32'(bus.almost_full), 32'(af));
        check({tag, ".overflow"}, 32'(bus.overflow), 32'(ov));
        check({tag, ".underflow"}, 32'(bus.underflow), 32'(un));
    endtask

    // One clock of stimulus; inputs change 1 time unit after the rising edge.
    task automatic op(input logic w, input logic [7:0] wd, input logic r, input logic c);
        bus.wr = w;
        bus.w_data = wd;
        bus.rd = r;
        bus.clr = c;
        @(posedge clk);
        #1;
        bus.wr = 1'b0;
        bus.rd = 1'b0;
        bus.clr = 1'b0;
    endtask

    task automatic wr_only(input logic [7:0] wd);
        op(1'b1, wd, 1'b0, 1'b0);
    endtask

    task automatic rd_only(input logic [7:0] expd);
        exp_q.push_back(expd);
        op(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    // Monitor: every accepted pop is compared against the head of the expected queue.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && bus.rd && !bus.empty && !bus.clr) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_unexpected: got 0x%0h, expected no pop at %0t",
                             bus.r_data, $time);
                end else begin
                    check("pop_data", 32'(bus.r_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        bus.wr = 1'b0;
        bus.rd = 1'b0;
        bus.clr = 1'b0;
        bus.w_data = 8'h00;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_status("reset", 0, 1, 0, 1, 0, 0, 0);
        reset = 1'b0;

        // 1. Fill 0x11..0x44
        wr_only(8'h11);
        check_status("fill1", 1, 0, 0, 1, 0, 0, 0);
        check("fill1.r_data", 32'(bus.r_data), 32'h11);
        wr_only(8'h22);
        check_status("fill2", 2, 0, 0, 0, 0, 0, 0);
        check("fill2.r_data", 32'(bus.r_data), 32'h11);
        wr_only(8'h33);
        check_status("fill3", 3, 0, 0, 0, 1, 0, 0);
        check("fill3.r_data", 32'(bus.r_data), 32'h11);
        wr_only(8'h44);
        check_status("fill4", 4, 0, 1, 0, 1, 0, 0);
        check("fill4.r_data", 32'(bus.r_data), 32'h11);

        // 2. Write into full FIFO is rejected
        wr_only(8'h55);
        check_status("ovf", 4, 0, 1, 0, 1, 1, 0);
        check("ovf.r_data", 32'(bus.r_data), 32'h11);
        rd_only(8'h11);
        rd_only(8'h22);
        rd_only(8'h33);
        rd_only(8'h44);
        check_status("drain2", 0, 1, 0, 1, 0, 1, 0);

        // 3. rd & wr on empty: only the write lands
        op(1'b1, 8'h66, 1'b1, 1'b0);
        check_status("emp_rw", 1, 0, 0, 1, 0, 1, 1);
        check("emp_rw.r_data", 32'(bus.r_data), 32'h66);
        rd_only(8'h66);
        check_status("emp_rd", 0, 1, 0, 1, 0, 1, 1);

        // Clear sticky flags before scenario 4
        op(1'b0, 8'h00, 1'b0, 1'b1);
        check_status("clr0", 0, 1, 0, 1, 0, 0, 0);

        // 4. rd & wr on full
        wr_only(8'h11);
        wr_only(8'h22);
        wr_only(8'h33);
        wr_only(8'h44);
        exp_q.push_back(8'h11);
        op(1'b1, 8'h77, 1'b1, 1'b0);
        check_status("full_rw", 4, 0, 1, 0, 1, 0, 0);
        check("full_rw.r_data", 32'(bus.r_data), 32'h22);
        rd_only(8'h22);
        rd_only(8'h33);
        rd_only(8'h44);
        rd_only(8'h77);
        check_status("drain4", 0, 1, 0, 1, 0, 0, 0);

        // 5. Ten write/read pairs across pointer wrap
        wr_only(8'h80);
        wr_only(8'h81);
        check("wrap.level_init", 32'(bus.level), 32'd2);
        for (int i = 2; i < 10; i++) begin
            exp_q.push_back(8'(8'h80 + i - 2));
            op(1'b1, 8'(8'h80 + i), 1'b1, 1'b0);
            check("wrap.level", 32'(bus.level), 32'd2);
        end
        rd_only(8'h88);
        rd_only(8'h89);
        check_status("wrap_end", 0, 1, 0, 1, 0, 0, 0);

        // 6. Level 3 with overflow, then clr with wr
        wr_only(8'hA0);
        wr_only(8'hA1);
        wr_only(8'hA2);
        wr_only(8'hA3);
        wr_only(8'hA4);
        rd_only(8'hA0);
        check_status("pre_clr", 3, 0, 0, 0, 1, 1, 0);
        op(1'b1, 8'hEE, 1'b0, 1'b1);
        check_status("clr_wr", 0, 1, 0, 1, 0, 0, 0);
        op(1'b0, 8'h00, 1'b0, 1'b0);
        check_status("clr_idle", 0, 1, 0, 1, 0, 0, 0);

        // Asynchronous reset in the middle of a burst
        wr_only(8'hB0);
        wr_only(8'hB1);
        wr_only(8'hB2);
        check("burst.level", 32'(bus.level), 32'd3);
        bus.wr = 1'b1;
        bus.w_data = 8'hB3;
        #2;
        reset = 1'b1;
        #1;
        check_status("async_rst", 0, 1, 0, 1, 0, 0, 0);
        bus.wr = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_status("post_rst", 0, 1, 0, 1, 0, 0, 0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_lvl.md
Name: fifo_lvl

Overview:
Parametrised synchronous FIFO. It extends the basic byte FIFO with an occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and a synchronous flush. It also defines read and write behaviour when both arrive at a full or empty boundary. It sits between producer/consumer blocks in the same clock domain (e.g. UART/keyboard RX to the control FSM, or the control FSM to the display path).

Parameters:
B, 8, data word width in bits
W, 4, address bits; depth = 2**W words
AF_LVL, 2**W-2, almost_full asserts when level >= AF_LVL; legal range 1..2**W
AE_LVL, 1, almost_empty asserts when level <= AE_LVL; must be < AF_LVL

Ports:
clk  in  1  clock, all state changes on rising edge
reset  in  1  asynchronous, active-high reset
clr  in  1  synchronous flush, highest priority after reset
wr  in  1  write request; w_data is captured if accepted
w_data  in  B  write data
rd  in  1  read request; pops the head word if accepted
r_data  out  B  head word (show-ahead, combinational from the storage at the read pointer)
empty  out  1  level == 0
full  out  1  level == 2**W
almost_empty  out  1  level <= AE_LVL
almost_full  out  1  level >= AF_LVL
level  out  W+1  current occupancy, 0..2**W
overflow  out  1  sticky: a write was rejected
underflow  out  1  sticky: a read was rejected

Behaviour:
- Reset is clk/reset as decided: reset asynchronous, active-high; clock clk.
- Reset values:
  - pointers = 0, level = 0
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0
  - overflow = 0, underflow = 0
  - storage contents are not reset
- All status outputs are registers computed from next-state level. They are valid in the cycle after the edge that changes level; there is no combinational path from rd/wr to any status output.
- Accept rules, evaluated on the current registered state:
  - wr_acc = wr & (~full | rd)
  - rd_acc = rd & ~empty
- Full with rd & wr: both are accepted. The new word is written at w_ptr (== r_ptr) on the same edge that the old head is popped. r_data before the edge is the old word. level stays 2**W and full stays 1.
- Empty with rd & wr: only the write is accepted. underflow is set and level becomes 1. No pass-through: r_data shows the new word from the next cycle.
- Normal rd & wr (0 < level < 2**W): both pointers advance and level is unchanged.
- Pointer advance: w_ptr += wr_acc and r_ptr += rd_acc, modulo 2**W (natural wrap). level_next = level + wr_acc - rd_acc, in W+1 bits.
- Errors:
  - overflow is set on any cycle with wr & ~wr_acc
  - underflow is set on any cycle with rd & ~rd_acc
  - both are sticky until clr or reset
- clr:
  - on the next edge, pointers and level go to 0 and empty/almost_empty go to 1; full/almost_full go to 0
  - overflow/underflow are cleared
  - rd and wr in the same cycle are ignored and do not raise error flags
  - storage is untouched
- r_data is unspecified while empty = 1.
- Reset mid-operation: all registers go immediately to reset values. A write in flight on the reset edge need not land.

Decomposition:
- Shared header: FIFO_B_DEFAULT and FIFO_W_DEFAULT constants, plus a depth macro (2**W).
- One sub-module, fifo_regfile (parameters B, W): a 2**W x B array with a synchronous write port (we, waddr, wdata) and an asynchronous read port (raddr, rdata). fifo_lvl instantiates it and holds all pointer, level, flag and error logic.

Test Plan:
All scenarios use B=8, W=2 (depth 4), AF_LVL=3, AE_LVL=1.
1. Reset, then write 0x11, 0x22, 0x33, 0x44 on consecutive cycles:
   - level steps 1, 2, 3, 4
   - almost_empty drops when level goes 1->2
   - almost_full rises at level 3, full rises at level 4
   - r_data = 0x11 throughout
2. From full, wr 0x55 alone:
   - overflow = 1, level stays 4, contents unchanged
   - then 4 reads return 0x11, 0x22, 0x33, 0x44 and empty = 1
3. Empty, rd & wr 0x66 in the same cycle:
   - underflow = 1, level = 1, r_data = 0x66 on the next cycle
   - a subsequent read returns 0x66, then empty = 1
4. Fill to 4, then rd & wr 0x77 for one cycle:
   - the popped word is 0x11, level stays 4, full stays 1, no overflow
   - draining returns 0x22, 0x33, 0x44, 0x77
5. Wrap: perform 10 write/read pairs with data 0x80..0x89 at level 1-2:
   - read order matches write order across pointer wrap
   - level never exceeds 2
6. With level 3 and overflow = 1:
   - pulse clr with wr=1 -> next cycle level = 0, empty = 1, overflow = 0, no write
   - assert reset asynchronously mid-burst -> outputs reach reset values before the next clk edge
